mem_sram_ctrl: RTL and testbench



---
 rtl/mem_sram_ctrl.sv | 90 +++++++++
 tb/tb_mem_sram_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: runs 32-bit loads/stores as two 16-bit phases on an
// asynchronous SRAM and stalls the pipeline until each access completes.
module mem_sram_ctrl #(
  parameter int          ACC_CYC   = 2,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Val_RM,
  output logic [31:0] mem_rdata,
  output logic        freeze,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CW       = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(ACC_CYC - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          is_wr;
  logic          req;
  logic          phase_last;
  logic [31:0]   off;
  logic          drive_en;
  logic [15:0]   wr_half;
  logic          unused_off;

  assign req        = MEM_R_EN | MEM_W_EN;
  assign phase_last = (cnt == CNT_LAST);
  assign off        = ALU_result - BASE_ADDR;
  // Only the word index inside a 2^19-byte window reaches the SRAM.
  assign unused_off = ^{off[31:19], off[1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_LO;
      S_LO:    if (phase_last) state_nxt = S_HI;
      S_HI:    if (phase_last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE || state == S_DONE || phase_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Stores win when both enables are set.
      if (state == S_IDLE && req) begin
        is_wr <= MEM_W_EN;
      end
      if (!is_wr && phase_last && state == S_LO) begin
        mem_rdata[15:0] <= SRAM_DQ;
      end
      if (!is_wr && phase_last && state == S_HI) begin
        mem_rdata[31:16] <= SRAM_DQ;
      end
    end
  end

  assign drive_en  = ~rst & is_wr & (state == S_LO || state == S_HI);
  assign wr_half   = (state == S_HI) ? Val_RM[31:16] : Val_RM[15:0];
  assign SRAM_WE_N = ~drive_en;
  assign SRAM_DQ   = drive_en ? wr_half : 16'hzzzz;
  assign SRAM_ADDR = {off[18:2], (state == S_HI)};

  // Dropping freeze in DONE lets the EXE->MEM register advance on that edge.
  assign freeze = req & (state != S_DONE) & ~rst;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: an SRAM model on the bus, a driver issuing
// accesses, and a monitor that checks each completed access against a queue.
module tb_mem_sram_ctrl;

  localparam int ACC_CYC = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] ALU_result = 32'd0;
  logic [31:0] Val_RM = 32'd0;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  logic [15:0] sram [0:262143];
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int frz_cnt = 0;
  int frz_total = 0;
  int done_seen = 0;
  int cyc = 0;

  mem_sram_ctrl #(.ACC_CYC(ACC_CYC), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result), .Val_RM(Val_RM), .mem_rdata(mem_rdata),
    .freeze(freeze), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_WE_N(SRAM_WE_N)
  );

  // clock / SRAM model (output enable tied active: drives whenever not writing)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;

  always @(posedge clk) begin
    if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: DONE is the cycle with a request present but freeze low
  always @(negedge clk) begin
    if (rst) begin
      frz_cnt = 0;
    end else if (freeze) begin
      frz_cnt++;
      frz_total++;
    end else if (MEM_R_EN | MEM_W_EN) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("done_rdata", mem_rdata, exp_q.pop_front());
        check("done_freeze_cycles", frz_cnt, 2 * ACC_CYC + 1);
      end
      frz_cnt = 0;
      done_seen++;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rdata);
    int d0;
    bit got;
    exp_q.push_back(exp_rdata);
    d0 = done_seen;
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    ALU_result = addr;
    Val_RM = data;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (done_seen != d0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("access_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    int c0;
    int f0;
    int noop_frz;
    int noop_we;
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;

    // reset with a store pending: nothing may reach the bus
    MEM_W_EN = 1'b1;
    ALU_result = 32'd1032;
    Val_RM = 32'h5A5A_A5A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_freeze", {31'd0, freeze}, 32'd0);
    check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("rst_dq_released", {16'd0, SRAM_DQ}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_state", {30'd0, dut.state}, {30'd0, S_IDLE});
    check("rst_addr", {14'd0, SRAM_ADDR}, 32'd4);
    @(posedge clk); #1;
    MEM_W_EN = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // store then load the same word
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0);
    check("st_lo_half", {16'd0, sram[4]}, 32'h0000_BEEF);
    check("st_hi_half", {16'd0, sram[5]}, 32'h0000_DEAD);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF);

    // no-op cycles: no stall, no writes
    noop_frz = 0;
    noop_we = 0;
    for (int i = 0; i < 10; i++) begin
      ALU_result = 32'd1024 + 32'(i * 4);
      @(negedge clk);
      if (freeze) noop_frz++;
      if (!SRAM_WE_N) noop_we++;
      @(posedge clk); #1;
    end
    check("noop_freeze", noop_frz, 0);
    check("noop_we", noop_we, 0);

    // back-to-back store and load
    c0 = cyc;
    f0 = frz_total;
    access(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678);
    check("b2b_cycles", cyc - c0, 12);
    check("b2b_stall", frz_total - f0, 10);

    // aliasing above bit 18 and ignored byte offset
    access(1'b1, 1'b0, 32'h0008_040B, 32'h0, 32'hDEADBEEF);

    // address below the base wraps to the top of the SRAM
    access(1'b0, 1'b1, 32'd1020, 32'h0F0F_1E1E, 32'hDEADBEEF);
    check("wrap_lo", {16'd0, sram[18'h3FFFE]}, 32'h0000_1E1E);
    check("wrap_hi", {16'd0, sram[18'h3FFFF]}, 32'h0000_0F0F);

    // reset during the HI phase of a store
    MEM_W_EN = 1'b1;
    ALU_result = 32'd1040;
    Val_RM = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    check("mid_state_hi", {30'd0, dut.state}, {30'd0, S_HI});
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("mid_state_idle", {30'd0, dut.state}, {30'd0, S_IDLE});
    check("mid_rdata", mem_rdata, 32'd0);
    check("mid_partial_lo", {16'd0, sram[8]}, 32'h0000_F00D);
    check("mid_partial_hi", {16'd0, sram[9]}, 32'h0000_0000);
    @(posedge clk); #1;

    // fresh load, then both enables (store wins), then read it back
    access(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'd1048, 32'h0BADC0DE, 32'hDEADBEEF);
    check("both_lo_half", {16'd0, sram[12]}, 32'h0000_C0DE);
    access(1'b1, 1'b0, 32'd1048, 32'h0, 32'h0BADC0DE);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
